// File: rtl/rr_hold_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_hold_arbiter
//  Brief    : Registered round-robin arbiter with grant locking and a bounded
//             hold time; the owner is forced off after MAX_HOLD cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_hold_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int MAX_HOLD  = 16,
  localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int CNT_W     = $clog2(MAX_HOLD + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] grant_o,
  output logic [IDX_W-1:0]     grant_idx_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [IDX_W-1:0] c_last_rst = IDX_W'(NUM_PORTS - 1);

  state_t               r_state;
  logic [NUM_PORTS-1:0] r_grant;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     r_last;
  logic [CNT_W-1:0]     r_hold_cnt;
  logic                 r_busy;
  logic                 r_timeout;

  logic                 w_owner_req;
  logic                 w_at_limit;
  logic                 w_keep;
  logic                 w_forced;
  logic [NUM_PORTS-1:0] w_cand;
  logic                 w_found;
  logic [IDX_W-1:0]     w_win;
  logic [NUM_PORTS-1:0] w_win_oh;

  // Owner's request is read through the one-hot grant, so no decode of r_idx.
  always_comb begin
    w_owner_req = |(req_i & r_grant);
    w_at_limit  = (r_hold_cnt == c_max_hold);
    w_keep      = (r_state == ST_GRANT) && w_owner_req && !w_at_limit;
    w_forced    = (r_state == ST_GRANT) && w_owner_req && w_at_limit;
    w_cand      = w_forced ? (req_i & ~r_grant) : req_i;
  end

  // Circular scan starting one past the last winner.
  always_comb begin : arb_scan
    int                 pos;
    logic [IDX_W-1:0]   pos_idx;
    w_found = 1'b0;
    w_win   = '0;
    pos     = 0;
    pos_idx = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      pos     = (int'(r_last) + k) % NUM_PORTS;
      pos_idx = IDX_W'(pos);
      if (!w_found && w_cand[pos_idx]) begin
        w_found = 1'b1;
        w_win   = pos_idx;
      end
    end
  end

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_win] = 1'b1;
  end

  // Any cycle that does not keep the current owner is an arbitration cycle,
  // which covers IDLE, voluntary release and forced release alike.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_idx      <= '0;
      r_last     <= c_last_rst;
      r_hold_cnt <= '0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_forced;
      if (w_keep) begin
        r_hold_cnt <= r_hold_cnt + c_cnt_one;
      end else if (w_found) begin
        r_state    <= ST_GRANT;
        r_grant    <= w_win_oh;
        r_idx      <= w_win;
        r_last     <= w_win;
        r_hold_cnt <= c_cnt_one;
        r_busy     <= 1'b1;
      end else begin
        r_state    <= ST_IDLE;
        r_grant    <= '0;
        r_hold_cnt <= '0;
        r_busy     <= 1'b0;
      end
    end
  end

  assign grant_o     = r_grant;
  assign grant_idx_o = r_idx;
  assign busy_o      = r_busy;
  assign timeout_o   = r_timeout;

endmodule
`default_nettype wire
